vga_timing_ctrl: RTL

Raster timing controller that sequences `pattern_gen_verilog`. It walks horizontal and vertical pixel counters through active, front-porch, sync and back-porch phases. It drives the generator's `x`, `y` and `von` inputs, and emits `hsync`/`vsync` aligned to the same pixel. Counters advance only on a pixel-rate clock enable, so one fast system clock can serve any pixel rate.

---
 rtl/vga_timing_pkg.sv | 27 ++
 rtl/vga_axis_counter.sv | 80 ++++++++
 rtl/vga_timing_ctrl.sv | 123 ++++++++++++
 3 files changed

// File: rtl/vga_timing_pkg.sv
// Shared types and widths for the VGA raster timing controller.
// Phase order ACTIVE -> FRONT -> SYNC -> BACK is the same for both axes.
package vga_timing_pkg;

   localparam int CNT_W = 11;
   localparam int POS_W = 10;

   typedef enum logic [1:0] {
      PH_ACTIVE = 2'd0,
      PH_FRONT  = 2'd1,
      PH_SYNC   = 2'd2,
      PH_BACK   = 2'd3
   } phase_e;

   function automatic phase_e next_phase(input phase_e p);
      phase_e n;
      case (p)
         PH_ACTIVE: n = PH_FRONT;
         PH_FRONT:  n = PH_SYNC;
         PH_SYNC:   n = PH_BACK;
         PH_BACK:   n = PH_ACTIVE;
         default:   n = PH_ACTIVE;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: position counter plus phase FSM with a phase-local count.
// pos/phase/active/sync_on present the values being loaded on the current edge.
module vga_axis_counter
   import vga_timing_pkg::*;
#(
   parameter int RES  = 640,
   parameter int FP   = 16,
   parameter int SYNC = 96,
   parameter int BP   = 48
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             advance,
   output logic [CNT_W-1:0] pos,
   output phase_e           phase,
   output logic             wrap,
   output logic             active,
   output logic             sync_on
);

   localparam logic [CNT_W-1:0] TOTAL_M1 = CNT_W'(RES + FP + SYNC + BP - 1);

   function automatic logic [CNT_W-1:0] len_m1(input phase_e p);
      logic [CNT_W-1:0] l;
      case (p)
         PH_ACTIVE: l = CNT_W'(RES - 1);
         PH_FRONT:  l = CNT_W'(FP - 1);
         PH_SYNC:   l = CNT_W'(SYNC - 1);
         PH_BACK:   l = CNT_W'(BP - 1);
         default:   l = CNT_W'(BP - 1);
      endcase
      return l;
   endfunction

   logic [CNT_W-1:0] pos_q, pos_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   phase_e           phase_q, phase_d;

   // State register; reset parks the axis on its last blanked position.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pos_q   <= TOTAL_M1;
         cnt_q   <= CNT_W'(BP - 1);
         phase_q <= PH_BACK;
      end else begin
         pos_q   <= pos_d;
         cnt_q   <= cnt_d;
         phase_q <= phase_d;
      end
   end

   // Next position and phase; the phase count restarts at each boundary.
   always_comb begin
      pos_d   = pos_q;
      cnt_d   = cnt_q;
      phase_d = phase_q;
      if (advance) begin
         if (pos_q == TOTAL_M1) begin
            pos_d = {CNT_W{1'b0}};
         end else begin
            pos_d = pos_q + 11'd1;
         end
         if (cnt_q == len_m1(phase_q)) begin
            cnt_d   = {CNT_W{1'b0}};
            phase_d = next_phase(phase_q);
         end else begin
            cnt_d   = cnt_q + 11'd1;
         end
      end else begin
         pos_d   = pos_q;
      end
   end

   assign wrap    = (pos_q == TOTAL_M1);
   assign pos     = pos_d;
   assign phase   = phase_d;
   assign active  = (phase_d == PH_ACTIVE);
   assign sync_on = (phase_d == PH_SYNC);

endmodule

// File: rtl/vga_timing_ctrl.sv
// Raster timing controller: two axis counters advanced on pix_tick, with
// registered x/y/von/syncs aligned to the same pixel and a frame_start pulse.
module vga_timing_ctrl
   import vga_timing_pkg::*;
#(
   parameter int   HRES      = 640,
   parameter int   HFP       = 16,
   parameter int   HSYNC     = 96,
   parameter int   HBP       = 48,
   parameter int   VRES      = 480,
   parameter int   VFP       = 10,
   parameter int   VSYNC     = 2,
   parameter int   VBP       = 33,
   parameter logic HSYNC_POL = 1'b0,
   parameter logic VSYNC_POL = 1'b0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             pix_tick,
   output logic [POS_W-1:0] x,
   output logic [POS_W-1:0] y,
   output logic             von,
   output logic             hsync,
   output logic             vsync,
   output logic             frame_start
);

   localparam int HTOTAL = HRES + HFP + HSYNC + HBP;
   localparam int VTOTAL = VRES + VFP + VSYNC + VBP;

   if (HRES > 1023 || VRES > 1023 || HTOTAL > 2047 || VTOTAL > 2047 ||
       HRES < 1 || HFP < 1 || HSYNC < 1 || HBP < 1 ||
       VRES < 1 || VFP < 1 || VSYNC < 1 || VBP < 1) begin : g_bad_params
      $error("vga_timing_ctrl: timing parameters out of range");
   end

   logic [CNT_W-1:0] h_pos, v_pos;
   phase_e           h_phase, v_phase;
   logic             h_wrap, v_wrap;
   logic             h_active, v_active;
   logic             h_sync_on, v_sync_on;
   logic             v_advance;
   logic             unused_ok;

   assign v_advance = pix_tick & h_wrap;

   vga_axis_counter #(.RES(HRES), .FP(HFP), .SYNC(HSYNC), .BP(HBP)) u_h_axis (
      .clk     (clk),
      .reset   (reset),
      .advance (pix_tick),
      .pos     (h_pos),
      .phase   (h_phase),
      .wrap    (h_wrap),
      .active  (h_active),
      .sync_on (h_sync_on)
   );

   vga_axis_counter #(.RES(VRES), .FP(VFP), .SYNC(VSYNC), .BP(VBP)) u_v_axis (
      .clk     (clk),
      .reset   (reset),
      .advance (v_advance),
      .pos     (v_pos),
      .phase   (v_phase),
      .wrap    (v_wrap),
      .active  (v_active),
      .sync_on (v_sync_on)
   );

   // Phase encodings and the 11th position bit are not needed at the outputs.
   assign unused_ok = ^{h_phase, v_phase, h_pos[CNT_W-1], v_pos[CNT_W-1]};

   logic [POS_W-1:0] x_q, x_d, y_q, y_d;
   logic             von_q, von_d;
   logic             hsync_q, hsync_d, vsync_q, vsync_d;
   logic             frame_start_q, frame_start_d;

   // Output registers load from the axis next values so all outputs align.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         x_q           <= {POS_W{1'b0}};
         y_q           <= {POS_W{1'b0}};
         von_q         <= 1'b0;
         hsync_q       <= ~HSYNC_POL;
         vsync_q       <= ~VSYNC_POL;
         frame_start_q <= 1'b0;
      end else begin
         x_q           <= x_d;
         y_q           <= y_d;
         von_q         <= von_d;
         hsync_q       <= hsync_d;
         vsync_q       <= vsync_d;
         frame_start_q <= frame_start_d;
      end
   end

   // Both axes wrapping on one tick is the only way to reach (0,0).
   always_comb begin
      x_d           = x_q;
      y_d           = y_q;
      von_d         = von_q;
      hsync_d       = hsync_q;
      vsync_d       = vsync_q;
      frame_start_d = 1'b0;
      if (pix_tick) begin
         von_d         = h_active & v_active;
         x_d           = (h_active & v_active) ? h_pos[POS_W-1:0] : {POS_W{1'b0}};
         y_d           = (h_active & v_active) ? v_pos[POS_W-1:0] : {POS_W{1'b0}};
         hsync_d       = h_sync_on ? HSYNC_POL : ~HSYNC_POL;
         vsync_d       = v_sync_on ? VSYNC_POL : ~VSYNC_POL;
         frame_start_d = h_wrap & v_wrap;
      end else begin
         frame_start_d = 1'b0;
      end
   end

   assign x           = x_q;
   assign y           = y_q;
   assign von         = von_q;
   assign hsync       = hsync_q;
   assign vsync       = vsync_q;
   assign frame_start = frame_start_q;

endmodule
